// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared state type, width helper and default sizes for the sequence detector
package seq_det_pkg;
  typedef enum logic {IDLE, RUN} state_e;
  localparam int DEF_PAT_W = 8;
  localparam int DEF_CNT_W = 8;
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction
endpackage

// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if: serial bit stream, configuration strobe and detector status
interface seq_detector_param_if #(
  parameter int PAT_W = seq_det_pkg::DEF_PAT_W,
  parameter int LEN_W = seq_det_pkg::len_w(PAT_W),
  parameter int CNT_W = seq_det_pkg::DEF_CNT_W
);
  logic             in;
  logic             in_valid;
  logic             cfg_load;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic             overlap;
  logic             z1;
  logic             z1_q;
  logic [CNT_W-1:0] match_cnt;
  logic             cfg_err;
  logic             running;
  modport master (
    output in, in_valid, cfg_load, pattern, pat_len, overlap,
    input  z1, z1_q, match_cnt, cfg_err, running
  );
  modport slave (
    input  in, in_valid, cfg_load, pattern, pat_len, overlap,
    output z1, z1_q, match_cnt, cfg_err, running
  );
endinterface

// File: rtl/seq_match_cmp.sv
// seq_match_cmp: compares the low pat_len bits of a candidate window against the pattern
module seq_match_cmp #(
  parameter int PAT_W = seq_det_pkg::DEF_PAT_W,
  parameter int LEN_W = seq_det_pkg::len_w(PAT_W)
) (
  input  logic [PAT_W-1:0] cand_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [LEN_W-1:0] pat_len_i,
  output logic             eq_o
);
  logic [PAT_W-1:0] mask;
  for (genvar g = 0; g < PAT_W; g++) begin : g_mask
    assign mask[g] = pat_len_i > LEN_W'(g);
  end
  assign eq_o = ((cand_i ^ pattern_i) & mask) == '0;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: run-time configurable serial pattern detector with Mealy and registered match,
// saturating match counter and sticky configuration-error flag
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = len_w(PAT_W),
  parameter int CNT_W = DEF_CNT_W
) (
  input logic                 clk,
  input logic                 reset,
  seq_detector_param_if.slave bus
);
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W - 1);
  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d, cand;
  logic [LEN_W-1:0] len_q, len_d, fill_q, fill_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovl_q, ovl_d, err_q, err_d, z1_dly_q;
  logic             eq, len_ok, fire, z1;
  assign cand = {hist_q, bus.in};
  seq_match_cmp #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_cmp (
    .cand_i    (cand),
    .pattern_i (pat_q),
    .pat_len_i (len_q),
    .eq_o      (eq)
  );
  assign len_ok = bus.pat_len != '0 && bus.pat_len <= LEN_W'(PAT_W);
  assign fire   = state_q == RUN && bus.in_valid && !bus.cfg_load;
  // fill counts history bits already held, so pat_len-1 of them plus the incoming bit complete a window
  assign z1     = fire && eq && fill_q >= len_q - LEN_W'(1);
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    err_d   = err_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = (z1 && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    if (bus.cfg_load) begin
      state_d = len_ok ? RUN : IDLE;
      err_d   = !len_ok;
      if (len_ok) begin
        pat_d  = bus.pattern;
        len_d  = bus.pat_len;
        ovl_d  = bus.overlap;
        hist_d = '0;
        fill_d = '0;
      end
    end else if (fire) begin
      hist_d = (z1 && !ovl_q) ? '0 : cand[PAT_W-2:0];
      fill_d = (z1 && !ovl_q) ? '0 : (fill_q == FILL_MAX ? fill_q : fill_q + LEN_W'(1));
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pat_q    <= '0;
      len_q    <= '0;
      ovl_q    <= 1'b0;
      err_q    <= 1'b0;
      hist_q   <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
      z1_dly_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      ovl_q    <= ovl_d;
      err_q    <= err_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      z1_dly_q <= z1;
    end
  end
  assign bus.z1        = z1;
  assign bus.z1_q      = z1_dly_q;
  assign bus.match_cnt = cnt_q;
  assign bus.cfg_err   = err_q;
  assign bus.running   = state_q == RUN;
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed and random checks of two detectors (8-bit and 2-bit counters) against a queue model
module tb_seq_detector_param;
  localparam int PW = 8;
  localparam int LW = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic          reset = 1'b1;
  logic          in_b = 1'b0, in_valid = 1'b0, cfg_load = 1'b0, overlap = 1'b0;
  logic [PW-1:0] pattern = '0;
  logic [LW-1:0] pat_len = '0;
  int errors = 0;
  int checks = 0;
  seq_detector_param_if #(.PAT_W(PW), .LEN_W(LW), .CNT_W(8)) b8 ();
  seq_detector_param_if #(.PAT_W(PW), .LEN_W(LW), .CNT_W(2)) b2 ();
  assign b8.in = in_b;       assign b2.in = in_b;
  assign b8.in_valid = in_valid; assign b2.in_valid = in_valid;
  assign b8.cfg_load = cfg_load; assign b2.cfg_load = cfg_load;
  assign b8.pattern = pattern;   assign b2.pattern = pattern;
  assign b8.pat_len = pat_len;   assign b2.pat_len = pat_len;
  assign b8.overlap = overlap;   assign b2.overlap = overlap;
  seq_detector_param #(.PAT_W(PW), .CNT_W(8)) dut8 (.clk(clk), .reset(reset), .bus(b8.slave));
  seq_detector_param #(.PAT_W(PW), .CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(b2.slave));
  // reference: hq holds the usable received bits in arrival order, oldest first
  bit            m_run, m_ovl, m_err, m_z1q;
  logic [PW-1:0] m_pat;
  int            m_len, m_cnt;
  bit            hq[$];
  task automatic m_reset();
    m_run = 0; m_ovl = 0; m_err = 0; m_z1q = 0; m_pat = '0; m_len = 0; m_cnt = 0;
    hq.delete();
  endtask
  function automatic bit m_match(input bit b);
    bit t[$];
    t = hq;
    t.push_back(b);
    if (!m_run || m_len == 0 || t.size() < m_len) return 0;
    for (int k = 0; k < m_len; k++)
      if (t[t.size() - m_len + k] != m_pat[m_len-1-k]) return 0;
    return 1;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic check_all(input bit ez);
    chk("z1", {31'b0, b8.z1}, {31'b0, ez});
    chk("z1_cnt2dut", {31'b0, b2.z1}, {31'b0, ez});
    chk("z1_q", {31'b0, b8.z1_q}, {31'b0, m_z1q});
    chk("match_cnt8", {24'b0, b8.match_cnt}, 32'(m_cnt > 255 ? 255 : m_cnt));
    chk("match_cnt2", {30'b0, b2.match_cnt}, 32'(m_cnt > 3 ? 3 : m_cnt));
    chk("cfg_err", {31'b0, b8.cfg_err}, {31'b0, m_err});
    chk("running", {31'b0, b8.running}, {31'b0, m_run});
  endtask
  task automatic step(input bit b, input bit v, input bit c, input logic [PW-1:0] p,
                      input logic [LW-1:0] l, input bit o);
    bit ez;
    @(negedge clk);
    in_b = b; in_valid = v; cfg_load = c; pattern = p; pat_len = l; overlap = o;
    #1;
    ez = v && !c && m_match(b);
    check_all(ez);
    @(posedge clk);
    m_z1q = ez;
    if (ez) m_cnt++;
    if (c) begin
      if (int'(l) >= 1 && int'(l) <= PW) begin
        m_run = 1; m_pat = p; m_len = int'(l); m_ovl = o; m_err = 0;
        hq.delete();
      end else begin
        m_err = 1; m_run = 0;
      end
    end else if (v && m_run) begin
      if (ez && !m_ovl) hq.delete();
      else begin
        hq.push_back(b);
        if (hq.size() > PW - 1) void'(hq.pop_front());
      end
    end
  endtask
  task automatic cfg(input logic [PW-1:0] p, input logic [LW-1:0] l, input bit o);
    step(1'b0, 1'b0, 1'b1, p, l, o);
  endtask
  task automatic sb(input bit b);
    step(b, 1'b1, 1'b0, '0, '0, 1'b0);
  endtask
  task automatic gap();
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; cfg_load = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 check_all(1'b0);
    @(negedge clk) reset = 1'b0;
  endtask
  initial begin
    bit rc;
    m_reset();
    do_reset();
    cfg(8'b0000_1100, 4'd4, 1'b0);
    sb(1); sb(1); sb(0); sb(0); gap();
    cfg(8'b0000_1010, 4'd4, 1'b1);
    sb(1); sb(0); sb(1); sb(0); sb(1); sb(0);
    cfg(8'b0000_1010, 4'd4, 1'b0);
    sb(1); sb(0); sb(1); sb(0); sb(1); sb(0); gap();
    cfg(8'b0000_1100, 4'd4, 1'b0);
    sb(1); sb(1); gap(); gap(); gap(); sb(0); sb(0); gap();
    cfg(8'b0000_1100, 4'd4, 1'b0);
    sb(1); sb(1); sb(0);
    @(negedge clk);
    #2 reset = 1'b1;
    m_reset();
    #1 check_all(1'b0);
    @(negedge clk) reset = 1'b0;
    sb(0); gap();
    cfg(8'b0000_1100, 4'd0, 1'b0);
    cfg(8'b0000_1100, 4'd9, 1'b0);
    cfg(8'b0000_1100, 4'd4, 1'b0);
    gap();
    do_reset();
    cfg(8'b0000_0001, 4'd1, 1'b0);
    sb(1); sb(1); sb(1); sb(1); sb(1); gap();
    cfg(8'($urandom), 4'($urandom_range(1, 4)), 1'($urandom));
    for (int i = 0; i < 600; i++) begin
      rc = $urandom_range(0, 24) == 0;
      step(1'($urandom), $urandom_range(0, 3) != 0, rc, 8'($urandom),
           $urandom_range(0, 1) != 0 ? 4'($urandom_range(1, 4)) : 4'($urandom_range(0, 9)),
           1'($urandom));
    end
    gap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
